// File: rtl/regfile_wb_pkg.sv
// Shared state encoding and default widths for the register-file writeback sequencer.
package regfile_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } wb_state_t;

  localparam int WB_NUM_SRC = 4;
  localparam int WB_DEPTH   = 8;
  localparam int WB_DATA_W  = 32;
  localparam int WB_REG_AW  = 5;

endpackage

// File: rtl/wb_rr_arbiter.sv
// NUM_SRC-way round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves to winner+1 only when the caller signals that the grant was taken.
module wb_rr_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] i_req,
  input  logic               i_en,
  input  logic               i_advance,
  output logic [NUM_SRC-1:0] o_grant
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_ptr_nxt;
  logic [NUM_SRC-1:0] w_grant;
  logic               w_found;

  always_comb begin
    w_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % NUM_SRC]) begin
        w_found                                 = 1'b1;
        w_grant[(int'(r_ptr) + k) % NUM_SRC]    = 1'b1;
        w_ptr_nxt                               = PW'((int'(r_ptr) + k + 1) % NUM_SRC);
      end
    end
  end

  assign o_grant = w_grant & {NUM_SRC{i_en}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Writeback sequencer: arbitrates result sources into an in-order FIFO and drives the regfile
// write port as SETUP (number/data) then a one-cycle STROBE. Optional lookup: WB_FWD_EN.
module regfile_wb_sequencer
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int DEPTH   = WB_DEPTH,
  parameter int DATA_W  = WB_DATA_W,
  parameter int REG_AW  = WB_REG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [REG_AW-1:0]         wr_reg_number,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_strobe,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      idle
`ifdef WB_FWD_EN
  ,
  input  logic [REG_AW-1:0]         fwd_reg,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic [AW:0]          w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [REG_AW-1:0]    r_mem_reg  [DEPTH];
  logic [DATA_W-1:0]    r_mem_data [DEPTH];
  logic [NUM_SRC-1:0]   w_grant;
  logic [REG_AW-1:0]    w_push_reg;
  logic [DATA_W-1:0]    w_push_data;
  logic [AW-1:0]        w_head_idx;
  wb_state_t            r_state;
  wb_state_t            w_state_nxt;
  logic                 r_wr_strobe;
  logic [REG_AW-1:0]    r_wr_reg;
  logic [DATA_W-1:0]    r_wr_data;

  // Ready depends only on the pre-pop full flag, never on this cycle's pop.
  wb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (src_valid),
    .i_en      (!w_full),
    .i_advance (w_push),
    .o_grant   (w_grant)
  );

  assign src_ready = w_grant;
  assign w_push    = |w_grant;

  always_comb begin
    w_push_reg  = '0;
    w_push_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_push_reg  = src_reg[i*REG_AW +: REG_AW];
        w_push_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = (r_state == STROBE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wptr[AW-1:0]]  <= w_push_reg;
      r_mem_data[r_wptr[AW-1:0]] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = STROBE;
      STROBE:  w_state_nxt = (w_count > (AW+1)'(1)) ? SETUP : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Leaving STROBE the current head is being popped, so the next entry is one further on.
  assign w_head_idx = (r_state == STROBE) ? (r_rptr[AW-1:0] + 1'b1) : r_rptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_strobe <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_strobe <= (w_state_nxt == STROBE);
      if (w_state_nxt == SETUP) begin
        r_wr_reg  <= r_mem_reg[w_head_idx];
        r_wr_data <= r_mem_data[w_head_idx];
      end
    end
  end

  assign wr_strobe     = r_wr_strobe;
  assign wr_reg_number = r_wr_reg;
  assign wr_data       = r_wr_data;
  assign pending       = w_count;
  assign idle          = w_empty && (r_state == IDLE);

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < w_count) &&
          (r_mem_reg[r_rptr[AW-1:0] + AW'(i)] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_mem_data[r_rptr[AW-1:0] + AW'(i)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench for regfile_wb_sequencer with a queue-based reference model checked every cycle.
module tb_regfile_wb_sequencer;

  localparam int NS    = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int RW    = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NS-1:0]      src_valid;
  logic [NS-1:0]      src_ready;
  logic [NS*RW-1:0]   src_reg;
  logic [NS*DW-1:0]   src_data;
  logic [RW-1:0]      wr_reg_number;
  logic [DW-1:0]      wr_data;
  logic               wr_strobe;
  logic [3:0]         pending;
  logic               idle;
`ifdef WB_FWD_EN
  logic [RW-1:0]      fwd_reg;
  logic               fwd_hit;
  logic [DW-1:0]      fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_sequencer #(.NUM_SRC(NS), .DEPTH(DEPTH), .DATA_W(DW), .REG_AW(RW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_reg       (src_reg),
    .src_data      (src_data),
    .wr_reg_number (wr_reg_number),
    .wr_data       (wr_data),
    .wr_strobe     (wr_strobe),
    .pending       (pending),
    .idle          (idle)
`ifdef WB_FWD_EN
    ,
    .fwd_reg       (fwd_reg),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           mq[$];
  wr_t           m_new;
  int            rr = 0;
  logic [DW-1:0] rf [32];
  int            acc_log[$];
  int            strobe_cyc[$];
  int            cyc = 0;
  int            gap = 0;
  int            n_strobes = 0;
  int            m_win;
  logic [NS-1:0] m_grant;
  logic          prev_strb = 1'b0;
  logic [RW-1:0] prev_reg = '0;
  logic [DW-1:0] prev_data = '0;
  bit            saw_full_stall = 0;
`ifdef WB_FWD_EN
  logic          m_hit;
  logic [DW-1:0] m_fdata;
`endif

  // Reference model: inputs are stable from negedge to the next posedge, so the model
  // checks the DUT here and then advances itself across the coming edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_strb = 1'b0;
      gap = 0;
    end else begin
      m_grant = '0;
      m_win = -1;
      if (mq.size() < DEPTH)
        for (int k = 0; k < NS; k++)
          if (m_win < 0 && src_valid[(rr + k) % NS]) m_win = (rr + k) % NS;
      if (m_win >= 0) m_grant[m_win] = 1'b1;
      chk("src_ready", src_ready, m_grant);
      chk("pending", pending, mq.size());
      chk("idle", idle, mq.size() == 0);
      if (pending == DEPTH && src_valid != 0 && src_ready == 0) saw_full_stall = 1;
      if (wr_strobe) begin
        n_strobes++;
        strobe_cyc.push_back(cyc);
        if (mq.size() == 0) chk("stray_strobe", wr_strobe, 0);
        else begin
          chk("wr_reg_number", wr_reg_number, mq[0].r);
          chk("wr_data", wr_data, mq[0].d);
        end
        chk("strobe_one_cycle", prev_strb, 0);
        chk("reg_setup_stable", wr_reg_number, prev_reg);
        chk("data_setup_stable", wr_data, prev_data);
        rf[wr_reg_number] = wr_data;
        gap = 0;
      end else if (mq.size() != 0) begin
        gap++;
        if (gap > 3) chk("strobe_stall", wr_strobe, 1);
      end else begin
        gap = 0;
      end
`ifdef WB_FWD_EN
      m_hit = 1'b0;
      m_fdata = '0;
      foreach (mq[i]) if (mq[i].r == fwd_reg) begin m_hit = 1'b1; m_fdata = mq[i].d; end
      chk("fwd_hit", fwd_hit, m_hit);
      chk("fwd_data", fwd_data, m_fdata);
`endif
      if (wr_strobe && mq.size() != 0) void'(mq.pop_front());
      if (m_win >= 0) begin
        m_new.r = src_reg[m_win*RW +: RW];
        m_new.d = src_data[m_win*DW +: DW];
        mq.push_back(m_new);
        rr = (m_win + 1) % NS;
        acc_log.push_back(m_win);
      end
      prev_strb = wr_strobe;
      prev_reg  = wr_reg_number;
      prev_data = wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int s, input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
    src_valid[s]       = v;
    src_reg[s*RW +: RW] = r;
    src_data[s*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    src_valid = '0;
    mq.delete();
    rr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && !idle; i++) @(negedge clk);
    chk(name, idle, 1);
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int base, sbase, ns0, j, guard;
  logic taken;

  initial begin
    rst_n = 1'b1;
    src_valid = '0;
    src_reg = '0;
    src_data = '0;
`ifdef WB_FWD_EN
    fwd_reg = '0;
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_reg", wr_reg_number, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_idle", idle, 1);
    chk("rst_src_ready", src_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write from src1: SETUP at +1, strobe at +2, idle after.
    drive_src(1, 1'b1, 5'd7, 32'hDEADBEEF);
    @(negedge clk); chk("t1_ready", src_ready, 4'b0010);
    step(); src_valid = '0;
    @(negedge clk); chk("t1_pending", pending, 1); chk("t1_no_strobe0", wr_strobe, 0);
    step();
    @(negedge clk); chk("t1_setup_reg", wr_reg_number, 7); chk("t1_setup_data", wr_data, 32'hDEADBEEF);
    chk("t1_no_strobe1", wr_strobe, 0);
    step();
    @(negedge clk); chk("t1_strobe", wr_strobe, 1); chk("t1_strobe_reg", wr_reg_number, 7);
    chk("t1_strobe_data", wr_data, 32'hDEADBEEF);
    step();
    @(negedge clk); chk("t1_strobe_drop", wr_strobe, 0); chk("t1_idle", idle, 1);

    // Round-robin with all sources valid.
    do_reset();
    base = acc_log.size();
    sbase = strobe_cyc.size();
    for (int s = 0; s < NS; s++) drive_src(s, 1'b1, RW'(s + 1), 32'hA0 + s);
    repeat (12) step();
    src_valid = '0;
    wait_drain("t2_drain");
    for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), acc_log[base + i], exp_rr[i]);
    chk("t2_strobe_gap0", strobe_cyc[sbase + 1] - strobe_cyc[sbase], 2);
    chk("t2_strobe_gap1", strobe_cyc[sbase + 2] - strobe_cyc[sbase + 1], 2);

    // Fill to full with back-to-back writes from src0.
    do_reset();
    saw_full_stall = 0;
    ns0 = n_strobes;
    j = 0;
    guard = 0;
    while (j < 20 && guard < 300) begin
      drive_src(0, 1'b1, RW'(j), 32'h3000 + j);
      @(negedge clk);
      taken = src_ready[0];
      step();
      if (taken) j++;
      guard++;
    end
    src_valid = '0;
    chk("t3_all_accepted", j, 20);
    wait_drain("t3_drain");
    chk("t3_saw_full_stall", saw_full_stall, 1);
    chk("t3_strobe_count", n_strobes - ns0, 20);

    // Same register twice: both issued, last one wins.
    do_reset();
    rf[3] = '0;
    ns0 = n_strobes;
    drive_src(2, 1'b1, 5'd3, 32'd1);
    step();
    drive_src(2, 1'b1, 5'd3, 32'd2);
    step();
    src_valid = '0;
    wait_drain("t4_drain");
    chk("t4_rf_r3", rf[3], 2);
    chk("t4_strobe_count", n_strobes - ns0, 2);

    // Asynchronous reset while the strobe is high.
    do_reset();
    drive_src(0, 1'b1, 5'd9, 32'h55);
    step();
    drive_src(0, 1'b1, 5'd10, 32'h66);
    step();
    src_valid = '0;
    for (int i = 0; i < 20 && !wr_strobe; i++) @(negedge clk);
    chk("t5_reach_strobe", wr_strobe, 1);
    #2 rst_n = 1'b0;
    mq.delete();
    rr = 0;
    #1;
    chk("t5_strobe_async_drop", wr_strobe, 0);
    chk("t5_pending_cleared", pending, 0);
    chk("t5_reg_cleared", wr_reg_number, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ns0 = n_strobes;
    repeat (10) step();
    chk("t5_no_stale_write", n_strobes - ns0, 0);
    chk("t5_idle", idle, 1);

`ifdef WB_FWD_EN
    // Forwarding returns the youngest pending match.
    do_reset();
    fwd_reg = 5'd5;
    drive_src(0, 1'b1, 5'd5, 32'h10);
    step();
    drive_src(0, 1'b1, 5'd5, 32'h20);
    step();
    src_valid = '0;
    @(negedge clk);
    chk("t6_fwd_hit", fwd_hit, 1);
    chk("t6_fwd_data", fwd_data, 32'h20);
    wait_drain("t6_drain");
    chk("t6_fwd_hit_after", fwd_hit, 0);
    chk("t6_fwd_data_after", fwd_data, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected end before 200000");
    $fatal(1);
  end

endmodule
